// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared constants, types and helpers for the AES block UART transmitter.
// Optional parity support is selected with the AES_UART_TX_PARITY_EN macro.
package aes_uart_pkg;

  localparam int N_DATA_BITS = 8;
  localparam int N_BYTES     = 16;
  localparam int OVERSAMPLE  = 13;

  localparam int BLOCK_W = N_BYTES * N_DATA_BITS;
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(N_DATA_BITS);
  localparam int BYTE_W  = $clog2(N_BYTES);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_DATA_BITS - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

  typedef logic [BLOCK_W-1:0] block_t;

  // Frame-level states of the serializer (ALIGN is only used by the block sequencer view).
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Block-level sequencing states owned by the top level.
  typedef enum logic [1:0] {
    BLK_IDLE,
    BLK_ALIGN,
    BLK_SEND
  } blk_state_t;

  // Even parity bit: makes the total count of ones in data+parity even.
  function automatic logic even_parity(input logic [N_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/aes_block_uart_tx_byte.sv
// uart_tx_byte: serializes one UART frame (start, data LSB first, optional parity, stop).
// A new frame can be chained directly onto the end of the stop bit so blocks go out gap-free.
// AES_UART_TX_PARITY_EN defined: an even parity bit is inserted after the data bits (8E1).
module uart_tx_byte
  import aes_uart_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic                   i_start,
  input  logic [N_DATA_BITS-1:0] i_data,
  output logic                   o_tx,
  output logic                   o_frame_done
);

  tx_state_t              state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [N_DATA_BITS-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
`ifdef AES_UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif
  logic                   wrap;
  logic                   frame_done;

  // The current bit ends on the i_en pulse that completes OVERSAMPLE periods.
  assign wrap = i_en && (tick_q == TICK_LAST);

  // Next-state logic: tick counting, bit sequencing and the next line level.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    frame_done = 1'b0;
`ifdef AES_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if ((state_q != ST_IDLE) && i_en) begin
      tick_d = wrap ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start && i_en) begin
          state_d  = ST_START;
          tick_d   = '0;
          shift_d  = i_data;
          tx_d     = 1'b0;
`ifdef AES_UART_TX_PARITY_EN
          parity_d = even_parity(i_data);
`endif
        end
      end
      ST_START: begin
        if (wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          if (bit_q == BIT_LAST) begin
`ifdef AES_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef AES_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (wrap) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (wrap) begin
          frame_done = 1'b1;
          if (i_start) begin
            state_d  = ST_START;
            shift_d  = i_data;
            tx_d     = 1'b0;
`ifdef AES_UART_TX_PARITY_EN
            parity_d = even_parity(i_data);
`endif
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Frame state register; reset returns the line to idle high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef AES_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef AES_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx         = tx_q;
  assign o_frame_done = frame_done;

endmodule

// File: rtl/aes_block_uart_tx.sv
// aes_block_uart_tx: accepts a 128-bit block over valid/ready and sends it as 16 UART
// frames, byte 0 first. Owns the handshake, the block buffer, byte sequencing and o_done.
// AES_UART_TX_PARITY_EN defined: frames carry an even parity bit (handled in uart_tx_byte).
module aes_block_uart_tx
  import aes_uart_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic [BLOCK_W-1:0] i_block,
  input  logic               i_block_valid,
  output logic               o_block_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic [BYTE_W-1:0]  o_byte_count,
  output logic               o_done
);

  blk_state_t        state_q, state_d;
  block_t            buf_q, buf_d;
  logic [BYTE_W-1:0] count_q, count_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              frame_start;
  logic              frame_done;
  logic              last_byte;

  assign last_byte = (count_q == BYTE_LAST);

  // Block sequencing: the buffer shifts one byte every time a frame is launched, so the
  // serializer always sees the next byte to send on the low bits.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      BLK_IDLE: begin
        if (i_block_valid && ready_q) begin
          buf_d   = i_block;
          state_d = BLK_ALIGN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      BLK_ALIGN: begin
        frame_start = 1'b1;
        if (i_en) begin
          state_d = BLK_SEND;
          buf_d   = buf_q >> N_DATA_BITS;
        end
      end
      BLK_SEND: begin
        frame_start = !last_byte;
        if (frame_done) begin
          if (last_byte) begin
            state_d = BLK_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
            buf_d   = buf_q >> N_DATA_BITS;
          end
        end
      end
      default: begin
        state_d = BLK_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // Block state and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= BLK_IDLE;
      buf_q   <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte u_tx_byte (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_en         (i_en),
    .i_start      (frame_start),
    .i_data       (buf_q[N_DATA_BITS-1:0]),
    .o_tx         (o_tx),
    .o_frame_done (frame_done)
  );

  assign o_block_ready = ready_q;
  assign o_busy        = busy_q;
  assign o_byte_count  = count_q;
  assign o_done        = done_q;

endmodule
